// File: rtl/control_unit.sv
// Multi-cycle control unit for a 16-bit accumulator-less RISC core.
// FETCH/EXEC/LOAD_WB/HALT sequencer; controls decode from the latched IR.
module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero_flag,
  input  logic        pos_flag,
  output logic [7:0]  pc,
  output logic        rf_write,
  output logic        imm_sel,
  output logic        mem_write,
  output logic        mem_sel,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  output logic [2:0]  rd_addr,
  output logic [15:0] imm_data,
  output logic [3:0]  alu_sel,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_LOAD_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_BP   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  op;
  logic [15:0] sext;
  logic [7:0]  br_target;
  logic        is_rtype;
  logic        is_mem_imm;
  logic        is_branch;
  logic        wr_op;
  logic        taken;

  assign op         = ir[15:12];
  assign sext       = {{10{ir[5]}}, ir[5:0]};
  assign br_target  = pc + sext[7:0];
  assign is_rtype   = ~op[3];
  assign is_mem_imm = (op == OP_ADDI) | (op == OP_LD) | (op == OP_ST);
  assign is_branch  = (op == OP_BZ) | (op == OP_BP);
  assign wr_op      = is_rtype | (op == OP_ADDI);
  assign taken      = ((op == OP_BZ) & zero_flag)
                    | ((op == OP_BP) & pos_flag);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= 8'h00;
      ir    <= 16'h0000;
    end else begin
      unique case (state)
        S_FETCH: begin
          ir    <= instr;
          pc    <= pc + 8'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (op == OP_LD)
            state <= S_LOAD_WB;
          if (op == OP_HALT)
            state <= S_HALT;
          if (is_branch && taken)
            pc <= br_target;
          if (op == OP_JMP)
            pc <= ir[7:0];
        end
        S_LOAD_WB: state <= S_FETCH;
        S_HALT:    state <= S_HALT;
        default:   state <= S_FETCH;
      endcase
    end
  end

  assign rd_addr = ir[11:9];
  assign rs_addr = ir[8:6];
  assign rt_addr = ir[5:3];

  // Operand controls depend only on IR, so LOAD_WB holds the EXEC address.
  always_comb begin
    alu_sel  = 4'h0;
    imm_sel  = 1'b0;
    imm_data = 16'h0000;
    unique case (1'b1)
      is_rtype:   alu_sel = {1'b0, op[2:0]};
      is_mem_imm: begin
        imm_sel  = 1'b1;
        imm_data = sext;
      end
      is_branch:  imm_sel = 1'b1;
      default:    ;
    endcase
  end

  // Write strobes are masked by reset in the same cycle it is sampled.
  assign rf_write  = ~reset
                   & (((state == S_EXEC) & wr_op)
                   | (state == S_LOAD_WB));
  assign mem_write = ~reset & (state == S_EXEC) & (op == OP_ST);
  assign mem_sel   = (state == S_LOAD_WB);
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model plus
// directed scenarios with literal expectations.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr;
  logic        zero_flag = 1'b0;
  logic        pos_flag = 1'b0;
  logic [7:0]  pc;
  logic        rf_write;
  logic        imm_sel;
  logic        mem_write;
  logic        mem_sel;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [2:0]  rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
  logic        halted;

  logic [15:0] rom [256];

  always #5 clock = ~clock;

  assign instr = rom[pc];

  control_unit dut (
    .clock     (clock),
    .reset     (reset),
    .instr     (instr),
    .zero_flag (zero_flag),
    .pos_flag  (pos_flag),
    .pc        (pc),
    .rf_write  (rf_write),
    .imm_sel   (imm_sel),
    .mem_write (mem_write),
    .mem_sel   (mem_sel),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .imm_data  (imm_data),
    .alu_sel   (alu_sel),
    .halted    (halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: which step of the current instruction we are in
  // (0 fetch, 1 execute, 2 load writeback), plus a halted latch.
  int          m_pc   = 0;
  int          m_step = 0;
  bit          m_halt = 1'b0;
  logic [15:0] m_ir   = 16'h0000;

  function automatic int imm6_val(logic [15:0] w);
    int v;
    v = int'(w[5:0]);
    if (v >= 32)
      v = v - 64;
    return v;
  endfunction

  always @(posedge clock) begin
    int op;
    op = int'(m_ir[15:12]);
    if (reset) begin
      m_pc   = 0;
      m_step = 0;
      m_halt = 1'b0;
      m_ir   = 16'h0000;
    end else if (!m_halt) begin
      if (m_step == 0) begin
        m_ir   = rom[m_pc];
        m_pc   = (m_pc + 1) % 256;
        m_step = 1;
      end else if (m_step == 1) begin
        m_step = (op == 9) ? 2 : 0;
        if (op == 15)
          m_halt = 1'b1;
        if ((op == 11 && zero_flag) || (op == 12 && pos_flag))
          m_pc = (m_pc + imm6_val(m_ir) + 256) % 256;
        if (op == 13)
          m_pc = int'(m_ir[7:0]);
      end else begin
        m_step = 0;
      end
    end
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic compare();
    int op;
    bit exp_rf;
    bit exp_mw;
    bit exp_isel;
    int exp_imm;
    int exp_alu;
    op = int'(m_ir[15:12]);
    exp_rf = !reset && !m_halt
           && ((m_step == 1 && op <= 8) || m_step == 2);
    exp_mw = !reset && !m_halt && m_step == 1 && op == 10;
    exp_isel = (op >= 8 && op <= 12);
    exp_imm = (op >= 8 && op <= 10) ? imm6_val(m_ir) : 0;
    exp_alu = (op < 8) ? op : 0;
    chk("pc", 16'(pc), 16'(m_pc));
    chk("rf_write", 16'(rf_write), 16'(exp_rf));
    chk("mem_write", 16'(mem_write), 16'(exp_mw));
    chk("mem_sel", 16'(mem_sel), 16'(!m_halt && m_step == 2));
    chk("halted", 16'(halted), 16'(m_halt));
    chk("imm_sel", 16'(imm_sel), 16'(exp_isel));
    chk("imm_data", imm_data, 16'(exp_imm));
    chk("alu_sel", 16'(alu_sel), 16'(exp_alu));
    chk("rd_addr", 16'(rd_addr), 16'((m_ir >> 9) & 7));
    chk("rs_addr", 16'(rs_addr), 16'((m_ir >> 6) & 7));
    chk("rt_addr", 16'(rt_addr), 16'((m_ir >> 3) & 7));
  endtask

  task automatic cyc(bit r, bit z, bit p);
    @(negedge clock);
    reset     = r;
    zero_flag = z;
    pos_flag  = p;
    #1;
    compare();
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++)
      rom[i] = 16'hE000;
  endtask

  function automatic logic [15:0] rand_word();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 4'hF && $urandom_range(0, 3) != 0)
      op = 4'hE;
    return {op, 12'($urandom)};
  endfunction

  initial begin
    fill_nop();
    rom[0] = 16'h8247;
    rom[1] = 16'h9443;

    // ADDI then LD
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("fetch_pc", 16'(pc), 16'h0000);
    chk("fetch_rf", 16'(rf_write), 16'h0);
    cyc(0, 0, 0);
    chk("addi_rf", 16'(rf_write), 16'h1);
    chk("addi_rd", 16'(rd_addr), 16'h1);
    chk("addi_imm", imm_data, 16'h0007);
    chk("addi_alu", 16'(alu_sel), 16'h0);
    chk("addi_pc", 16'(pc), 16'h0001);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("ld_exec_rf", 16'(rf_write), 16'h0);
    chk("ld_exec_imm", imm_data, 16'h0003);
    cyc(0, 0, 0);
    chk("ld_wb_sel", 16'(mem_sel), 16'h1);
    chk("ld_wb_rf", 16'(rf_write), 16'h1);
    chk("ld_wb_rd", 16'(rd_addr), 16'h2);
    chk("ld_wb_imm", imm_data, 16'h0003);
    cyc(0, 0, 0);
    chk("ld_next_pc", 16'(pc), 16'h0002);

    // reset landing on LOAD_WB
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("rst_wb_rf", 16'(rf_write), 16'h0);
    cyc(0, 0, 0);
    chk("rst_wb_pc", 16'(pc), 16'h0000);
    chk("rst_wb_sel", 16'(mem_sel), 16'h0);

    // BZ at pc 5, back by 2 when taken
    fill_nop();
    rom[0] = 16'hD005;
    rom[5] = 16'hB03E;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("bz_fetch_pc", 16'(pc), 16'h0005);
    cyc(0, 1, 0);
    chk("bz_isel", 16'(imm_sel), 16'h1);
    chk("bz_imm", imm_data, 16'h0000);
    cyc(0, 0, 0);
    chk("bz_taken_pc", 16'(pc), 16'h0004);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("bz_not_taken_pc", 16'(pc), 16'h0006);

    // JMP 0xFF then pc wrap
    fill_nop();
    rom[0] = 16'hD0FF;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("jmp_pc", 16'(pc), 16'h00FF);
    cyc(0, 0, 0);
    chk("wrap_pc", 16'(pc), 16'h0000);

    // HALT
    fill_nop();
    rom[0] = 16'hF000;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("halt_exec_rf", 16'(rf_write), 16'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'($urandom), 1'($urandom));
      chk("halt_flag", 16'(halted), 16'h1);
      chk("halt_pc", 16'(pc), 16'h0001);
      chk("halt_rf", 16'(rf_write), 16'h0);
      chk("halt_mw", 16'(mem_write), 16'h0);
    end
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("halt_rst_pc", 16'(pc), 16'h0000);
    chk("halt_rst_flag", 16'(halted), 16'h0);

    // random programs with random flags and occasional reset
    for (int i = 0; i < 256; i++)
      rom[i] = rand_word();
    cyc(1, 0, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
